cfg_muxn_bank: RTL and testbench

CFG_MUXN_BANK -- requirements
Module: cfg_muxn_bank

---
 rtl/cfg_muxn_bank.sv | 60 ++++++
 tb/tb_cfg_muxn_bank.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_muxn_bank.sv
// Bank of NOUT independent IWIDTH:1 muxes configured through a serial shift chain.
// Each channel picks one shared input and presents it either combinationally or through a flop.
module cfg_muxn_bank #(
    parameter int IWIDTH = 20,
    parameter int SWIDTH = 5,
    parameter int NOUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_in,
    output logic              cfg_out,
    input  logic              ce,
    input  logic [IWIDTH-1:0] I,
    output logic [NOUT-1:0]   O
);
    localparam int CW = SWIDTH + 1;
    localparam int L  = NOUT * CW;
    localparam int PW = 2 ** SWIDTH;

    logic [L-1:0]    cfg;
    logic [PW-1:0]   ipad;
    logic [NOUT-1:0] m;
    logic [NOUT-1:0] mode;
    logic [NOUT-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cfg <= '0;
        else if (cfg_en)
            cfg <= {cfg[L-2:0], cfg_in};
    end

    assign cfg_out = cfg[L-1];

    // Zero-padding the inputs to the full select range makes out-of-range selects read 0.
    always_comb begin
        ipad             = '0;
        ipad[IWIDTH-1:0] = I;
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_ch
        assign m[k]    = ipad[cfg[k*CW +: SWIDTH]];
        assign mode[k] = cfg[k*CW+SWIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (ce && !cfg_en)
            q <= m;
    end

    // Outputs are held low for the whole reconfiguration window.
    always_comb begin
        O = '0;
        if (!cfg_en)
            O = (mode & q) | (~mode & m);
    end
endmodule

// File: tb/tb_cfg_muxn_bank.sv
// Self-checking bench for cfg_muxn_bank: expected {cfg_out, O} values are queued when
// stimulus is applied and popped for comparison once the DUT has responded.
module tb_cfg_muxn_bank;
    localparam int IW = 20;
    localparam int SW = 5;
    localparam int NO = 4;
    localparam int LL = NO * (SW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic          cfg_in = 1'b0;
    logic          ce = 1'b0;
    logic [IW-1:0] I = 20'hF57CE;
    logic          cfg_out;
    logic [NO-1:0] O;

    int tests = 0;
    int fails = 0;
    logic [4:0] sb[$];

    // reference model state
    logic [LL-1:0] mc = '0;
    logic [NO-1:0] mq = '0;

    cfg_muxn_bank #(.IWIDTH(IW), .SWIDTH(SW), .NOUT(NO)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(cfg_in),
        .cfg_out(cfg_out), .ce(ce), .I(I), .O(O)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic m_of(input logic [LL-1:0] c, input logic [IW-1:0] iv, input int k);
        int sel;
        sel = int'((c >> (k * 6)) & 24'd31);
        if (sel < IW) return iv[sel];
        return 1'b0;
    endfunction

    function automatic logic [NO-1:0] exp_o();
        logic [NO-1:0] o;
        o = '0;
        if (!cfg_en)
            for (int k = 0; k < NO; k++)
                o[k] = mc[k*6+5] ? mq[k] : m_of(mc, I, k);
        return o;
    endfunction

    task automatic tick();
        logic [NO-1:0] mn;
        @(posedge clk);
        if (rst) begin
            mc = '0;
            mq = '0;
        end else begin
            for (int k = 0; k < NO; k++) mn[k] = m_of(mc, I, k);
            if (ce && !cfg_en) mq = mn;
            if (cfg_en) mc = {mc[LL-2:0], cfg_in};
        end
        #1;
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        mc = '0;
        mq = '0;
    endtask

    task automatic load_cfg(input logic [LL-1:0] v);
        cfg_en = 1'b1;
        for (int i = LL - 1; i >= 0; i--) begin
            cfg_in = v[i];
            tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        rst = 1'b1;
        I = 20'hF57CE;
        for (int n = 0; n < 6; n++) begin
            cfg_in = 1'($urandom);
            cfg_en = 1'($urandom);
            ce     = 1'($urandom);
            sb.push_back(5'b0_0000);
            tick();
            e = sb.pop_front();
            tests++;
            if ({cfg_out, O} !== e) begin
                fails++;
                $display("FAIL reset_hold: got %b expected %b", {cfg_out, O}, e);
            end
        end
        cfg_en = 1'b0;
        I = 20'hF57CF;
        sb.push_back(5'b0_1111);
        #1;
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL reset_i0: got %b expected %b", {cfg_out, O}, e);
        end
        rst = 1'b0;
        ce = 1'b0;
        sb.push_back(5'b0_1111);
        tick();
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL reset_release: got %b expected %b", {cfg_out, O}, e);
        end
    endtask

    task automatic test_sweep();
        logic [4:0]    e;
        logic [LL-1:0] v;
        logic [IW-1:0] iv;
        logic [NO-1:0] eo;
        iv = 20'hF57CE;
        I  = iv;
        ce = 1'b0;
        for (int k = 0; k < NO; k++) begin
            for (int s = 0; s < 32; s++) begin
                v = '0;
                v[k*6 +: 5] = 5'(s);
                load_cfg(v);
                cfg_en = 1'b0;
                eo = '0;
                eo[k] = (s < IW) ? iv[s] : 1'b0;
                sb.push_back({1'b0, eo});
                #1;
                e = sb.pop_front();
                tests++;
                if ({cfg_out, O} !== e) begin
                    fails++;
                    $display("FAIL sweep ch%0d sel%0d: got %b expected %b", k, s, {cfg_out, O}, e);
                end
            end
        end
    endtask

    task automatic test_mixed();
        logic [4:0]    e;
        logic [LL-1:0] vm;
        vm = {1'b1, 5'd19, 1'b0, 5'd25, 1'b1, 5'd4, 1'b0, 5'd3};
        ce = 1'b1;
        I  = 20'hF57CE;
        load_cfg(vm);
        cfg_en = 1'b0;
        sb.push_back(5'b1_1001);
        tick();
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL mixed_first: got %b expected %b", {cfg_out, O}, e);
        end
        I = 20'h00010;
        sb.push_back(5'b1_1000);
        #1;
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL mixed_comb: got %b expected %b", {cfg_out, O}, e);
        end
        sb.push_back(5'b1_0010);
        tick();
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL mixed_reg: got %b expected %b", {cfg_out, O}, e);
        end
    endtask

    task automatic test_ce_hold();
        logic [4:0] e;
        pulse_rst();
        ce = 1'b1;
        I  = 20'hF57CE;
        load_cfg(24'h000900);
        cfg_en = 1'b0;
        tick();
        ce = 1'b0;
        for (int n = 0; n < 5; n++) begin
            I = n[0] ? 20'h00000 : 20'hFFFFF;
            sb.push_back({1'b0, exp_o()});
            #1;
            e = sb.pop_front();
            tests++;
            if ({cfg_out, O} !== e || O[1] !== 1'b0) begin
                fails++;
                $display("FAIL ce_hold cyc%0d: got %b expected %b", n, {cfg_out, O}, e);
            end
            tick();
        end
        ce = 1'b1;
        for (int n = 0; n < 8; n++) begin
            I = 20'($urandom);
            sb.push_back({1'b0, exp_o()});
            #1;
            e = sb.pop_front();
            tests++;
            if ({cfg_out, O} !== e) begin
                fails++;
                $display("FAIL ce_track_pre cyc%0d: got %b expected %b", n, {cfg_out, O}, e);
            end
            tick();
            sb.push_back({1'b0, exp_o()});
            e = sb.pop_front();
            tests++;
            if ({cfg_out, O} !== e) begin
                fails++;
                $display("FAIL ce_track_post cyc%0d: got %b expected %b", n, {cfg_out, O}, e);
            end
        end
    endtask

    task automatic test_pass_through();
        logic [4:0]    e;
        logic [LL-1:0] pat;
        logic          b;
        pat = 24'hA5C396;
        pulse_rst();
        sb.delete();
        for (int n = 0; n < LL - 1; n++) sb.push_back(5'b0_0000);
        cfg_en = 1'b1;
        for (int j = 0; j < 2 * LL; j++) begin
            b = (j < LL) ? pat[LL-1-j] : 1'b0;
            cfg_in = b;
            sb.push_back({b, 4'b0000});
            tick();
            e = sb.pop_front();
            tests++;
            if ({cfg_out, O} !== e) begin
                fails++;
                $display("FAIL chain shift%0d: got %b expected %b", j + 1, {cfg_out, O}, e);
            end
        end
        sb.delete();
        cfg_en = 1'b0;
    endtask

    task automatic test_reset_midconfig();
        logic [4:0]    e;
        logic [LL-1:0] vm;
        vm = {1'b1, 5'd19, 1'b0, 5'd25, 1'b1, 5'd4, 1'b0, 5'd3};
        I  = 20'hF57CF;
        pulse_rst();
        ce = 1'b1;
        load_cfg(vm);
        cfg_en = 1'b0;
        sb.push_back(5'b1_1001);
        tick();
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL midcfg_preload: got %b expected %b", {cfg_out, O}, e);
        end
        cfg_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cfg_in = n[0];
            tick();
        end
        #1 rst = 1'b1;
        mc = '0;
        mq = '0;
        sb.push_back(5'b0_0000);
        #1;
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL midcfg_async: got %b expected %b", {cfg_out, O}, e);
        end
        rst = 1'b0;
        cfg_en = 1'b0;
        ce = 1'b0;
        sb.push_back(5'b0_1111);
        #1;
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL midcfg_cleared: got %b expected %b", {cfg_out, O}, e);
        end
        load_cfg(vm);
        cfg_en = 1'b0;
        sb.push_back(5'b1_0001);
        #1;
        e = sb.pop_front();
        tests++;
        if ({cfg_out, O} !== e) begin
            fails++;
            $display("FAIL midcfg_q_cleared: got %b expected %b", {cfg_out, O}, e);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_mixed();
        test_ce_hold();
        test_pass_through();
        test_reset_midconfig();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
